// File: rtl/apple1_pkg.sv
// Shared definitions for the Apple 1 core keyboard path.
// Contents:
//   kbd_src_e      - character source identifier (PS/2 or UART)
//   kbd_state_e    - keyboard output register states
//   KBD_STROBE_BIT - KBD data bit that is forced high while a character is pending
//   to_upper       - folds ASCII a-z onto A-Z, leaves every other code untouched
package apple1_pkg;

   typedef enum logic {
      SRC_PS2  = 1'b0,
      SRC_UART = 1'b1
   } kbd_src_e;

   typedef enum logic [1:0] {
      KBD_EMPTY = 2'd0,
      KBD_LOAD  = 2'd1,
      KBD_FULL  = 2'd2
   } kbd_state_e;

   localparam int unsigned KBD_STROBE_BIT = 7;

   function automatic logic [6:0] to_upper(input logic [6:0] c);
      if (c >= 7'h61 && c <= 7'h7A) begin
         return c & 7'h5F;
      end
      return c;
   endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Small synchronous 7-bit character FIFO with show-ahead output.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push, din  - write din at the tail; caller only pushes when not full or popping
//   pop        - drop the head entry; caller only pops when not empty
//   dout       - current head entry (valid while !empty)
//   empty/full - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module kbd_char_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [6:0] din,
   output logic [6:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [6:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q;
   logic [AW:0] rptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   // A push while full is only legal alongside a pop; the write lands in the
   // slot being vacated, while dout still shows the old head this cycle.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rptr_q[AW-1:0]];
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/kbd_input_arbiter.sv
// Keyboard-input scheduler: merges UART and PS/2 character streams into the
// single KBD data register read by the 6502 through the PIA.
// Ports:
//   clk25, rst              - core clock, synchronous active-high reset
//   uart_valid, uart_data   - UART byte strobe and byte
//   ps2_valid, ps2_data     - PS/2 ASCII byte strobe and byte
//   en_uart, en_ps2         - per-source accept enables (do not flush queued bytes)
//   kbd_rd                  - CPU read strobe of the KBD data register
//   kbd_data                - pending character, bit 7 set while kbd_ready
//   kbd_ready               - KBDCR bit 7, character pending
//   ovf_uart, ovf_ps2       - one-cycle pulse after a byte was dropped on a full FIFO
module kbd_input_arbiter
   import apple1_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned UPCASE     = 1
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       uart_valid,
   input  logic [7:0] uart_data,
   input  logic       ps2_valid,
   input  logic [7:0] ps2_data,
   input  logic       en_uart,
   input  logic       en_ps2,
   input  logic       kbd_rd,
   output logic [7:0] kbd_data,
   output logic       kbd_ready,
   output logic       ovf_uart,
   output logic       ovf_ps2
);

   kbd_state_e state_q, state_d;
   kbd_src_e   last_q, last_d, winner;
   logic [7:0] data_q, data_d;
   logic       ovf_uart_q, ovf_ps2_q;

   logic       uart_req, uart_push, uart_pop, uart_empty, uart_full, uart_drop;
   logic       ps2_req, ps2_push, ps2_pop, ps2_empty, ps2_full, ps2_drop;
   logic [6:0] uart_dout, ps2_dout, pick, folded;

   // Source bit 7 is intentionally discarded; only 7-bit ASCII is queued.
   logic unused_bit7;
   assign unused_bit7 = uart_data[7] ^ ps2_data[7];

   assign uart_req = uart_valid && en_uart;
   assign ps2_req  = ps2_valid && en_ps2;

   // A full FIFO still accepts when its head is popped in the same cycle.
   assign uart_push = uart_req && (!uart_full || uart_pop);
   assign ps2_push  = ps2_req && (!ps2_full || ps2_pop);
   assign uart_drop = uart_req && uart_full && !uart_pop;
   assign ps2_drop  = ps2_req && ps2_full && !ps2_pop;

   kbd_char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_uart_fifo (
      .clk   (clk25),
      .rst   (rst),
      .push  (uart_push),
      .pop   (uart_pop),
      .din   (uart_data[6:0]),
      .dout  (uart_dout),
      .empty (uart_empty),
      .full  (uart_full)
   );

   kbd_char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_ps2_fifo (
      .clk   (clk25),
      .rst   (rst),
      .push  (ps2_push),
      .pop   (ps2_pop),
      .din   (ps2_data[6:0]),
      .dout  (ps2_dout),
      .empty (ps2_empty),
      .full  (ps2_full)
   );

   // Round-robin: UART wins when it alone has data, or on a tie after PS/2 won.
   assign winner   = (!uart_empty && (ps2_empty || last_q == SRC_PS2)) ? SRC_UART : SRC_PS2;
   assign pick     = (winner == SRC_UART) ? uart_dout : ps2_dout;
   assign folded   = (UPCASE != 0) ? to_upper(pick) : pick;
   assign uart_pop = (state_q == KBD_LOAD) && (winner == SRC_UART);
   assign ps2_pop  = (state_q == KBD_LOAD) && (winner == SRC_PS2);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      data_d  = data_q;
      unique case (state_q)
         // Look ahead at incoming strobes so a fresh byte reaches LOAD the next cycle.
         KBD_EMPTY: begin
            if (!uart_empty || !ps2_empty || uart_req || ps2_req) state_d = KBD_LOAD;
         end
         KBD_LOAD: begin
            data_d                 = {1'b0, folded};
            data_d[KBD_STROBE_BIT] = 1'b1;
            last_d                 = winner;
            state_d                = KBD_FULL;
         end
         KBD_FULL: begin
            if (kbd_rd) state_d = KBD_EMPTY;
         end
         default: state_d = KBD_EMPTY;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         state_q    <= KBD_EMPTY;
         last_q     <= SRC_PS2;
         data_q     <= 8'h00;
         ovf_uart_q <= 1'b0;
         ovf_ps2_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         data_q     <= data_d;
         ovf_uart_q <= uart_drop;
         ovf_ps2_q  <= ps2_drop;
      end
   end

   assign kbd_data  = data_q;
   assign kbd_ready = (state_q == KBD_FULL);
   assign ovf_uart  = ovf_uart_q;
   assign ovf_ps2   = ovf_ps2_q;

endmodule

// File: tb/tb_kbd_input_arbiter.sv
// Self-checking bench for kbd_input_arbiter: expected characters are queued
// when stimulus is driven and compared as the DUT presents them.
module tb_kbd_input_arbiter;

   logic       clk25;
   logic       rst;
   logic       uart_valid;
   logic [7:0] uart_data;
   logic       ps2_valid;
   logic [7:0] ps2_data;
   logic       en_uart;
   logic       en_ps2;
   logic       kbd_rd;
   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       ovf_uart;
   logic       ovf_ps2;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   kbd_input_arbiter #(
      .FIFO_DEPTH (4),
      .UPCASE     (1)
   ) dut (
      .clk25      (clk25),
      .rst        (rst),
      .uart_valid (uart_valid),
      .uart_data  (uart_data),
      .ps2_valid  (ps2_valid),
      .ps2_data   (ps2_data),
      .en_uart    (en_uart),
      .en_ps2     (en_ps2),
      .kbd_rd     (kbd_rd),
      .kbd_data   (kbd_data),
      .kbd_ready  (kbd_ready),
      .ovf_uart   (ovf_uart),
      .ovf_ps2    (ovf_ps2)
   );

   initial clk25 = 1'b0;
   always #5 clk25 = ~clk25;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic wait_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         if (kbd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk25);
      end
      if (kbd_ready === 1'b1) ok = 1'b1;
   endtask

   task automatic pulse_rd();
      kbd_rd = 1'b1;
      @(negedge clk25);
      kbd_rd = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk25);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk25);
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", kbd_ready); end
      checks++; if (kbd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", kbd_data); end
      checks++; if (ovf_uart !== 1'b0) begin errors++; $display("FAIL reset_ovf_uart: got %b want 0", ovf_uart); end
      checks++; if (ovf_ps2 !== 1'b0) begin errors++; $display("FAIL reset_ovf_ps2: got %b want 0", ovf_ps2); end
      rst = 1'b0;
      @(negedge clk25);
   endtask

   task automatic test_single_uart();
      logic [7:0] want;
      uart_data = 8'h61; uart_valid = 1'b1; exp_q.push_back(8'hC1);
      @(negedge clk25);
      uart_valid = 1'b0;
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL single_ready_n1: got %b want 0", kbd_ready); end
      @(negedge clk25);
      checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL single_ready_n2: got %b want 1", kbd_ready); end
      want = exp_q.pop_front();
      checks++; if (kbd_data !== want) begin errors++; $display("FAIL single_data: got %h want %h", kbd_data, want); end
      pulse_rd();
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_rd: got %b want 0", kbd_ready); end
      checks++; if (kbd_data !== want) begin errors++; $display("FAIL single_data_hold: got %h want %h", kbd_data, want); end
   endtask

   task automatic test_tie();
      bit ok;
      logic [7:0] want;
      do_reset();
      uart_data = 8'h41; ps2_data = 8'h0D; uart_valid = 1'b1; ps2_valid = 1'b1;
      @(negedge clk25);
      uart_data = 8'h42; ps2_data = 8'h0E;
      @(negedge clk25);
      uart_valid = 1'b0; ps2_valid = 1'b0;
      exp_q.push_back(8'hC1); exp_q.push_back(8'h8D);
      exp_q.push_back(8'hC2); exp_q.push_back(8'h8E);
      for (int i = 0; i < 4; i++) begin
         wait_ready(12, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL tie_timeout[%0d]: ready %b want 1", i, kbd_ready); end
         else begin
            want = exp_q.pop_front();
            checks++;
            if (kbd_data !== want) begin errors++; $display("FAIL tie_data[%0d]: got %h want %h", i, kbd_data, want); end
            pulse_rd();
         end
      end
   endtask

   task automatic test_case_fold();
      bit ok;
      logic [7:0] want;
      logic [7:0] src [4];
      logic [7:0] res [4];
      exp_q.delete();
      src[0] = 8'h7A; src[1] = 8'h7B; src[2] = 8'h60; src[3] = 8'hE1;
      res[0] = 8'hDA; res[1] = 8'hFB; res[2] = 8'hE0; res[3] = 8'hC1;
      for (int i = 0; i < 4; i++) begin
         uart_data = src[i]; uart_valid = 1'b1; exp_q.push_back(res[i]);
         @(negedge clk25);
      end
      uart_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_ready(12, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL fold_timeout[%0d]: ready %b want 1", i, kbd_ready); end
         else begin
            want = exp_q.pop_front();
            checks++;
            if (kbd_data !== want) begin errors++; $display("FAIL fold_data[%0d]: got %h want %h", i, kbd_data, want); end
            pulse_rd();
         end
      end
   endtask

   task automatic test_ps2_overflow();
      bit ok;
      logic [7:0] want;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         ps2_data = 8'h31 + 8'(i); ps2_valid = 1'b1;
         if (i < 5) exp_q.push_back(8'hB1 + 8'(i));
         @(negedge clk25);
         ps2_valid = 1'b0;
         if (i == 5) begin
            checks++; if (ovf_ps2 !== 1'b1) begin errors++; $display("FAIL ovf_ps2_pulse: got %b want 1", ovf_ps2); end
         end else begin
            checks++; if (ovf_ps2 !== 1'b0) begin errors++; $display("FAIL ovf_ps2_early[%0d]: got %b want 0", i, ovf_ps2); end
         end
         if (i == 0) repeat (4) @(negedge clk25);
      end
      @(negedge clk25);
      checks++; if (ovf_ps2 !== 1'b0) begin errors++; $display("FAIL ovf_ps2_single: got %b want 0", ovf_ps2); end
      for (int i = 0; i < 5; i++) begin
         wait_ready(12, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL ovf_timeout[%0d]: ready %b want 1", i, kbd_ready); end
         else begin
            want = exp_q.pop_front();
            checks++;
            if (kbd_data !== want) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, kbd_data, want); end
            pulse_rd();
         end
      end
      repeat (4) @(negedge clk25);
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL ovf_dropped_byte: ready %b want 0", kbd_ready); end
   endtask

   task automatic test_disabled();
      en_ps2 = 1'b0;
      ps2_data = 8'h41; ps2_valid = 1'b1;
      @(negedge clk25);
      ps2_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (ovf_ps2 !== 1'b0) begin errors++; $display("FAIL dis_ovf[%0d]: got %b want 0", i, ovf_ps2); end
         checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL dis_ready[%0d]: got %b want 0", i, kbd_ready); end
         @(negedge clk25);
      end
      en_ps2 = 1'b1;
      repeat (3) @(negedge clk25);
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL dis_not_queued: ready %b want 0", kbd_ready); end
   endtask

   task automatic test_push_pop_full();
      bit ok;
      logic [7:0] want;
      exp_q.delete();
      uart_data = 8'h50; uart_valid = 1'b1; exp_q.push_back(8'hD0);
      @(negedge clk25);
      uart_valid = 1'b0;
      repeat (2) @(negedge clk25);
      for (int i = 1; i <= 4; i++) begin
         uart_data = 8'h50 + 8'(i); uart_valid = 1'b1; exp_q.push_back(8'hD0 + 8'(i));
         @(negedge clk25);
      end
      uart_valid = 1'b0;
      checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL ppf_ready: got %b want 1", kbd_ready); end
      want = exp_q.pop_front();
      checks++; if (kbd_data !== want) begin errors++; $display("FAIL ppf_first: got %h want %h", kbd_data, want); end
      pulse_rd();
      @(negedge clk25);
      // LOAD cycle: the FIFO is full and pops its head while 0x55 is pushed.
      uart_data = 8'h55; uart_valid = 1'b1; exp_q.push_back(8'hD5);
      @(negedge clk25);
      checks++; if (ovf_uart !== 1'b0) begin errors++; $display("FAIL ppf_no_ovf: got %b want 0", ovf_uart); end
      uart_data = 8'h56;
      @(negedge clk25);
      uart_valid = 1'b0;
      checks++; if (ovf_uart !== 1'b1) begin errors++; $display("FAIL ppf_still_full: got %b want 1", ovf_uart); end
      for (int i = 0; i < 5; i++) begin
         wait_ready(12, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL ppf_timeout[%0d]: ready %b want 1", i, kbd_ready); end
         else begin
            want = exp_q.pop_front();
            checks++;
            if (kbd_data !== want) begin errors++; $display("FAIL ppf_data[%0d]: got %h want %h", i, kbd_data, want); end
            pulse_rd();
         end
      end
      repeat (4) @(negedge clk25);
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL ppf_extra_char: ready %b want 0", kbd_ready); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         uart_data = 8'h61 + 8'(i); ps2_data = 8'h71 + 8'(i);
         uart_valid = 1'b1; ps2_valid = 1'b1;
         @(negedge clk25);
      end
      uart_valid = 1'b0; ps2_valid = 1'b0;
      wait_ready(12, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_ready: got %b want 1", kbd_ready); end
      rst = 1'b1;
      @(negedge clk25);
      rst = 1'b0;
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_low: got %b want 0", kbd_ready); end
      checks++; if (kbd_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", kbd_data); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk25);
         checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: ready %b want 0", i, kbd_ready); end
      end
   endtask

   initial begin
      rst = 1'b1; uart_valid = 1'b0; uart_data = 8'h00; ps2_valid = 1'b0; ps2_data = 8'h00;
      en_uart = 1'b1; en_ps2 = 1'b1; kbd_rd = 1'b0;
      @(negedge clk25);
      test_reset();
      test_single_uart();
      test_tie();
      test_case_fold();
      test_ps2_overflow();
      test_disabled();
      test_push_pop_full();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
